// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Optional build macro: SYSID_CHECK_TIMEOUT_EN (enables the stall timeout).
package sysid_check_pkg;

  // Check sequencer states; BOOT is the power-on/reset state.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Word addresses inside the sysid slave.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Default expectations for a matching FPGA image / software build.
  localparam logic [31:0] DEF_EXPECTED_ID    = 32'd0;
  localparam logic [31:0] DEF_EXPECTED_TS    = 32'd1579698382;
  localparam bit          DEF_CHECK_TS       = 1'b1;
  localparam int          DEF_TIMEOUT_CYCLES = 255;

  // Width of a counter that must hold values 0..n (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Stall counter for the sysid checker: counts consecutive stalled read
// cycles and flags the cycle in which the limit is reached. Only
// instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_wait_timer
  import sysid_check_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);

  localparam int           W    = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  // Count stalled cycles; cleared whenever the sequencer changes state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is the stalled cycle that would make the count reach LIMIT.
  assign o_expire = i_count_en && (r_count == LAST);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID word, then timestamp
// word) after reset and on every start pulse accepted in DONE, and
// reports a sticky done/pass status to board logic.
// Optional build macro: SYSID_CHECK_TIMEOUT_EN (abort a stalled read
// after TIMEOUT_CYCLES and raise err_timeout).
// Handshake: a read is accepted at a rising edge where avm_read=1 and
// avm_waitrequest=0; address/read stay stable until then, and
// avm_readdata is sampled on that same edge.
module nios_system_sysid_checker
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter bit          CHECK_TS       = DEF_CHECK_TS,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_expire;
  logic        w_restart;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_pass;

  assign w_accept  = avm_read && !avm_waitrequest;
  assign w_restart = (r_state == DONE) && start;

`ifdef SYSID_CHECK_TIMEOUT_EN
  logic w_timer_clear;
  logic r_err_timeout;

  assign w_timer_clear = (w_next != r_state);

  sysid_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_clear   (w_timer_clear),
    .i_count_en(avm_read && avm_waitrequest),
    .o_expire  (w_expire)
  );

  // Timeout flag: set when a stalled read is abandoned, cleared on restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_restart) begin
      r_err_timeout <= 1'b0;
    end else if (w_expire) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_expire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; an accept in the expiry cycle takes priority.
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:    w_next = RD_ID;
      RD_ID: begin
        if (w_accept)      w_next = RD_TS;
        else if (w_expire) w_next = DONE;
      end
      RD_TS: begin
        if (w_accept || w_expire) w_next = DONE;
      end
      DONE: begin
        if (start) w_next = RD_ID;
      end
      default: w_next = BOOT;
    endcase
  end

  // Latch read data and register the comparison result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_pass     <= 1'b0;
    end else begin
      if (r_state == RD_ID && w_accept) begin
        r_id_value <= avm_readdata;
      end
      if (r_state == RD_TS && w_accept) begin
        r_ts_value <= avm_readdata;
        r_pass     <= (r_id_value == EXPECTED_ID) &&
                      (!CHECK_TS || (avm_readdata == EXPECTED_TS));
      end else if (w_restart || w_expire) begin
        r_pass <= 1'b0;
      end
    end
  end

  // Bus strobes and status decode from the state register only.
  assign avm_read    = (r_state == RD_ID) || (r_state == RD_TS);
  assign avm_address = (r_state == RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy        = avm_read;
  assign done        = (r_state == DONE);
  assign pass        = r_pass;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: two instances (timestamp checked /
// ignored) share one behavioural sysid slave with scripted stall counts.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1579698382;
  localparam int          TO     = 4;
`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;

  logic        a_addr, a_read, a_wait, a_busy, a_done, a_pass, a_err;
  logic [31:0] a_rdata, a_id, a_ts;
  logic [1:0]  a_dbg;
  logic        b_addr, b_read, b_busy, b_done, b_pass, b_err;
  logic [31:0] b_id, b_ts;
  logic [1:0]  b_dbg;

  // Slave model: memory words plus remaining stall cycles per word.
  logic [31:0] mem0 = EXP_ID;
  logic [31:0] mem1 = EXP_TS;
  int          id_left = 0;
  int          ts_left = 0;

  // Model of the values the checker should currently hold.
  logic [31:0] m_id = '0;
  logic [31:0] m_ts = '0;

  always #5 clock = ~clock;

  assign a_wait  = a_read & (a_addr ? (ts_left > 0) : (id_left > 0));
  assign a_rdata = a_addr ? mem1 : mem0;

  always @(posedge clock) begin
    if (reset_n && a_read && a_wait) begin
      if (a_addr) ts_left <= ts_left - 1;
      else        id_left <= id_left - 1;
    end
  end

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b1), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .id_value(a_id), .ts_value(a_ts),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_timeout(a_err),
    .dbg_state(a_dbg)
  );

  nios_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .CHECK_TS(1'b0), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .id_value(b_id), .ts_value(b_ts),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_timeout(b_err),
    .dbg_state(b_dbg)
  );

  // Hold reset (asserted mid-cycle) and reset the model.
  task automatic apply_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    m_id = '0;
    m_ts = '0;
  endtask

  // One full check, launched by reset release or a start pulse in DONE.
  // poke>0 raises start for one cycle at that cycle number.
  task automatic run_check(input int sid, input int sts, input bit from_reset,
                           input int poke, input string tag);
    int          exp_done;
    int          got;
    bit          exp_to;
    bit          exp_pa;
    bit          exp_pb;
    logic [31:0] exp_id;
    logic [31:0] exp_ts;
    exp_to   = 1'b0;
    exp_id   = mem0;
    exp_ts   = mem1;
    exp_done = 3 + sid + sts;
    if (TO_EN && sid >= TO) begin
      exp_to = 1'b1; exp_done = 1 + TO; exp_id = m_id; exp_ts = m_ts;
    end else if (TO_EN && sts >= TO) begin
      exp_to = 1'b1; exp_done = 2 + sid + TO; exp_ts = m_ts;
    end
    exp_pa = !exp_to && (exp_id == EXP_ID) && (exp_ts == EXP_TS);
    exp_pb = !exp_to && (exp_id == EXP_ID);
    got = 0;
    @(negedge clock);
    id_left = sid;
    ts_left = sts;
    if (from_reset) reset_n = 1'b1;
    else            start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 4 && got == 0; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      if (cyc == 1 && !from_reset) start = 1'b0;
      if (poke != 0 && cyc == poke) start = 1'b1;
      if (poke != 0 && cyc == poke + 1) start = 1'b0;
      total++;
      if ((a_pass & ~a_done) !== 1'b0) begin
        bad++;
        $display("FAIL %s pass_without_done: cycle %0d pass=%b done=%b", tag, cyc, a_pass, a_done);
      end
      if (a_done === 1'b1) begin
        got = cyc;
      end else begin
        total++;
        if (a_read !== 1'b1 || a_busy !== 1'b1 || a_addr !== (cyc > 1 + sid)) begin
          bad++;
          $display("FAIL %s bus_phase: cycle %0d read=%b busy=%b addr=%b want 1 1 %b",
                   tag, cyc, a_read, a_busy, a_addr, (cyc > 1 + sid));
        end
        total++;
        if (a_id !== ((cyc > 1 + sid) ? mem0 : m_id)) begin
          bad++;
          $display("FAIL %s id_hold: cycle %0d got %h want %h", tag, cyc, a_id,
                   (cyc > 1 + sid) ? mem0 : m_id);
        end
      end
    end
    total++;
    if (got != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, got, exp_done);
    end
    total++;
    if (a_id !== exp_id || a_ts !== exp_ts) begin
      bad++;
      $display("FAIL %s values: id=%h ts=%h want id=%h ts=%h", tag, a_id, a_ts, exp_id, exp_ts);
    end
    total++;
    if (a_pass !== exp_pa || a_err !== exp_to || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s status: pass=%b err=%b busy=%b want %b %b 0",
               tag, a_pass, a_err, a_busy, exp_pa, exp_to);
    end
    total++;
    if (b_pass !== exp_pb || {b_done, b_err, b_read, b_busy} !== {1'b1, exp_to, 2'b00} ||
        b_id !== exp_id || b_ts !== exp_ts || b_addr !== a_addr || b_dbg !== a_dbg) begin
      bad++;
      $display("FAIL %s no_ts_instance: pass=%b done=%b err=%b id=%h ts=%h want pass=%b err=%b id=%h ts=%h",
               tag, b_pass, b_done, b_err, b_id, b_ts, exp_pb, exp_to, exp_id, exp_ts);
    end
    m_id = exp_id;
    m_ts = exp_ts;
    if (poke != 0) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clock);
        @(negedge clock);
        total++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== exp_pa) begin
          bad++;
          $display("FAIL %s no_rerun: hold %0d done=%b busy=%b pass=%b", tag, k, a_done, a_busy, a_pass);
        end
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #2;
    total++;
    if ({a_read, a_addr, a_busy, a_done, a_pass, a_err, a_id, a_ts} !== '0 ||
        {b_read, b_addr, b_busy, b_done, b_pass, b_err, b_id, b_ts} !== '0) begin
      bad++;
      $display("FAIL reset_values: a=%b/%h/%h b=%b/%h/%h want all zero",
               {a_read, a_addr, a_busy, a_done, a_pass, a_err}, a_id, a_ts,
               {b_read, b_addr, b_busy, b_done, b_pass, b_err}, b_id, b_ts);
    end
  endtask

  task automatic test_match();
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    run_check(0, 0, 1'b1, 0, "match");
  endtask

  task automatic test_ts_mismatch();
    mem0 = EXP_ID;
    mem1 = EXP_TS + 32'd1;
    apply_reset();
    run_check(0, 0, 1'b1, 0, "ts_mismatch");
  endtask

  task automatic test_stall();
    mem0 = $urandom | 32'h1;
    mem1 = EXP_TS;
    apply_reset();
    run_check(5, 0, 1'b1, 0, "stall_id");
  endtask

  task automatic test_restart();
    mem0 = EXP_ID;
    mem1 = $urandom;
    run_check(0, 1, 1'b0, 0, "restart");
  endtask

  task automatic test_ignore_start();
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    run_check(0, 2, 1'b0, 3, "ignore_start");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      mem0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      mem1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_check($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 0, "random");
    end
  endtask

  // start held high: a new check every three cycles (RD_ID, RD_TS, DONE).
  task automatic test_back_to_back();
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    @(negedge clock);
    id_left = 0;
    ts_left = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clock);
      @(negedge clock);
      total++;
      if (a_done !== (cyc % 3 == 0) || (a_done === 1'b1 && a_pass !== 1'b1)) begin
        bad++;
        $display("FAIL back_to_back: cycle %0d done=%b pass=%b want done=%b", cyc, a_done, a_pass,
                 (cyc % 3 == 0));
      end
    end
    start = 1'b0;
    m_id = mem0;
    m_ts = mem1;
  endtask

  task automatic test_reset_mid();
    mem0 = $urandom;
    mem1 = $urandom;
    @(negedge clock);
    id_left = 0;
    ts_left = 3;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if (a_addr !== 1'b1 || a_read !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_phase: addr=%b read=%b want 1 1", a_addr, a_read);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({a_read, a_addr, a_busy, a_done, a_pass, a_err, a_id, a_ts} !== '0) begin
      bad++;
      $display("FAIL reset_mid_values: ctl=%b id=%h ts=%h want all zero",
               {a_read, a_addr, a_busy, a_done, a_pass, a_err}, a_id, a_ts);
    end
    m_id = '0;
    m_ts = '0;
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    run_check(0, 0, 1'b1, 0, "after_reset_mid");
  endtask

`ifdef SYSID_CHECK_TIMEOUT_EN
  task automatic test_timeout();
    mem0 = $urandom;
    mem1 = $urandom;
    run_check(100, 0, 1'b0, 0, "timeout_id");
    mem0 = EXP_ID;
    mem1 = EXP_TS;
    run_check(TO - 1, 0, 1'b0, 0, "release_at_limit");
    mem1 = $urandom;
    run_check(0, TO, 1'b0, 0, "timeout_ts");
  endtask
`endif

  initial begin
    test_reset();
    test_match();
    test_ts_mismatch();
    test_stall();
    test_restart();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SYSID_CHECK_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
